booth_mul_sched: RTL and testbench

Sequential radix-2 Booth multiplier shared between `N_REQ` requesters. A round-robin scheduler grants one requester at a time and latches its signed operands. A single iterative Booth engine then processes one multiplier bit per cycle. The engine returns the signed product and the requester ID through a valid/ready result port. The block replaces replicated combinational Booth arrays where area matters more than throughput.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/booth_mul_sched.sv | 138 +++++++++++++
 tb/tb_booth_mul_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the shared Booth multiplier.
// Holds the FSM encoding, Booth pair codes and the ID width helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// Returns a one-hot grant and the matching encoded index.
module rr_arbiter
  import booth_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);

  // scan from ptr, wrapping once, and keep the first hit
  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/booth_mul_sched.sv
// Radix-2 Booth multiplier shared by N_REQ requesters.
// Round-robin grant, one multiplier bit per cycle, valid/ready result.
module booth_mul_sched
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = 2,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*WIDTH-1:0]     res_z,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ZW = 2 * WIDTH;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gidx;
  logic [ID_W-1:0]   ptr_nxt;
  logic [ID_W-1:0]   id_q;
  logic [N_REQ-1:0]  gnt;
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_q;
  logic [WIDTH-1:0]  sel_x;
  logic [WIDTH-1:0]  sel_y;
  logic [WIDTH:0]    x_ext;
  logic [1:0]        pair;
  logic [ZW-1:0]     acc;
  logic [ZW-1:0]     addend;
  logic [ZW-1:0]     acc_nxt;
  logic [CW-1:0]     cnt;
  logic              last;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gidx)
  );

  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign res_z     = acc;
  assign res_id    = id_q;

  assign ptr_nxt = (int'(gidx) == N_REQ - 1) ? '0 : gidx + ID_W'(1);

  // route the granted requester's operands to the latch inputs
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (gnt[r]) begin
        sel_x = req_x[r*WIDTH +: WIDTH];
        sel_y = req_y[r*WIDTH +: WIDTH];
      end
    end
  end

  // X with an implicit zero below bit 0 gives the pair {X[i], X[i-1]}
  assign x_ext  = {x_q, 1'b0};
  assign pair   = x_ext[cnt +: 2];
  assign addend = {{WIDTH{y_q[WIDTH-1]}}, y_q} << cnt;
  assign last   = (cnt == CW'(WIDTH - 1));

  // one Booth step: add, subtract or keep the shifted multiplicand
  always_comb begin
    acc_nxt = acc;
    unique case (1'b1)
      (pair == BOOTH_ADD): acc_nxt = acc + addend;
      (pair == BOOTH_SUB): acc_nxt = acc - addend;
      default:             acc_nxt = acc;
    endcase
  end

  // scheduler and engine FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            x_q    <= sel_x;
            y_q    <= sel_y;
            id_q   <= gidx;
            acc    <= '0;
            cnt    <= '0;
            rr_ptr <= ptr_nxt;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched.
// Behavioural model plus directed and randomized stimulus.
module tb_booth_mul_sched;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int IW = 1;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] res_z;
  logic [IW-1:0]  res_id;
  logic           busy;

  booth_mul_sched #(
    .WIDTH(W),
    .N_REQ(N),
    .ID_W (IW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_z    (res_z),
    .res_id   (res_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit             m_idle = 1;
  bit             m_done = 0;
  int             m_left = 0;
  int             m_ptr  = 0;
  int             m_id   = 0;
  logic [2*W-1:0] m_prod = '0;
  int             n_res  = 0;
  int             waitc[N];
  logic [N-1:0]   gnt_seen = '0;

  function automatic int first_from(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int           g;
    int           px;
    int           py;
    logic [N-1:0] expr;
    gnt_seen = req_ready;
    if (!rst_n) begin
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res_z", 32'(res_z), 0);
      check("rst_res_id", 32'(res_id), 0);
      check("rst_busy", 32'(busy), 0);
      m_idle = 1;
      m_done = 0;
      m_left = 0;
      m_ptr  = 0;
      for (int r = 0; r < N; r++) waitc[r] = 0;
    end else begin
      g    = first_from(req_valid, m_ptr);
      expr = '0;
      if (m_idle && g >= 0) expr[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(expr));
      check("res_valid", 32'(res_valid), 32'(m_done));
      check("busy", 32'(busy), 32'(!m_idle));
      if (m_done) begin
        check("res_z", 32'(res_z), 32'(m_prod));
        check("res_id", 32'(res_id), 32'(m_id));
      end
      for (int r = 0; r < N; r++) if (!req_valid[r]) waitc[r] = 0;
      if (m_idle) begin
        if (g >= 0) begin
          px     = int'($signed(req_x[g*W +: W]));
          py     = int'($signed(req_y[g*W +: W]));
          m_prod = (2*W)'(px * py);
          m_id   = g;
          m_ptr  = (g + 1) % N;
          m_idle = 0;
          m_left = W;
          for (int r = 0; r < N; r++) begin
            if (r == g) waitc[r] = 0;
            else if (req_valid[r]) begin
              waitc[r]++;
              check("starvation", 32'(waitc[r] < N), 1);
            end
          end
        end
      end else if (!m_done) begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (res_ready) begin
        m_done = 0;
        m_idle = 1;
        n_res++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_res(output bit ok, output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
    end
    ok = res_valid;
    if (!ok) fail_now("result_timeout");
  endtask

  task automatic do_op(input int r, input logic [W-1:0] xv,
                       input logic [W-1:0] yv, output logic [2*W-1:0] z,
                       output int id, output int lat);
    bit got;
    bit ok;
    z   = '0;
    id  = -1;
    lat = -1;
    req_x[r*W +: W] = xv;
    req_y[r*W +: W] = yv;
    req_valid[r]    = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1;
    end
    if (!got) begin
      fail_now("grant_timeout");
      req_valid[r] = 1'b0;
      return;
    end
    tick();
    req_valid[r] = 1'b0;
    req_x[r*W +: W] = ~xv;
    wait_res(ok, lat);
    if (!ok) return;
    z  = res_z;
    id = int'(res_id);
    tick();
  endtask

  function automatic logic [W-1:0] rand_op();
    int s;
    s = int'($urandom_range(0, 9));
    if (s == 0) return 8'h80;
    if (s == 1) return 8'h7f;
    if (s == 2) return 8'hff;
    return W'($urandom);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [2*W-1:0] z;
    int             id;
    int             lat;
    bit             ok;
    int             gl[$];
    int             il[$];
    logic [2*W-1:0] zl[$];
    int             exp_g[4];
    logic [2*W-1:0] exp_z[4];
    bit             pend[N];
    bit             got;
    int             target;
    int             cyc;

    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single operation with latency
    do_op(0, 8'd3, 8'hfb, z, id, lat);
    check("single_z", 32'(z), 32'h0000fff1);
    check("single_id", 32'(id), 0);
    check("single_latency", 32'(lat), 8);

    // corner products
    do_op(0, 8'h80, 8'h80, z, id, lat);
    check("neg128_sq", 32'(z), 32'h00004000);
    do_op(1, 8'h80, 8'h7f, z, id, lat);
    check("neg128_x127", 32'(z), 32'h0000c080);
    check("neg128_x127_id", 32'(id), 1);
    do_op(0, 8'h00, 8'hff, z, id, lat);
    check("zero_x_m1", 32'(z), 32'h00000000);
    do_op(1, 8'hff, 8'hff, z, id, lat);
    check("m1_x_m1", 32'(z), 32'h00000001);

    // fairness from reset
    req_x[0 +: W] = 8'd7;
    req_y[0 +: W] = 8'd6;
    req_x[W +: W] = 8'hf7;
    req_y[W +: W] = 8'd11;
    req_valid     = 2'b11;
    do_reset();
    for (int k = 0; k < 120 && il.size() < 4; k++) begin
      @(negedge clk);
      if (|req_ready) gl.push_back(req_ready[1] ? 1 : 0);
      if (res_valid && res_ready) begin
        il.push_back(int'(res_id));
        zl.push_back(res_z);
      end
    end
    tick();
    req_valid = '0;
    if (il.size() < 4) fail_now("fairness_results");
    exp_g = '{0, 1, 0, 1};
    exp_z = '{16'd42, 16'hff9d, 16'd42, 16'hff9d};
    for (int k = 0; k < 4; k++) begin
      check("fair_grant", 32'(k < gl.size() ? gl[k] : -1), 32'(exp_g[k]));
      check("fair_id", 32'(k < il.size() ? il[k] : -1), 32'(exp_g[k]));
      check("fair_z", 32'(k < zl.size() ? zl[k] : 16'hdead), 32'(exp_z[k]));
    end

    // back-pressure with req1 pending
    res_ready     = 1'b0;
    req_x[0 +: W] = 8'd12;
    req_y[0 +: W] = 8'hfd;
    req_valid[0]  = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    if (!got) fail_now("bp_grant");
    tick();
    req_valid[0]  = 1'b0;
    req_x[W +: W] = 8'd2;
    req_y[W +: W] = 8'd3;
    req_valid[1]  = 1'b1;
    wait_res(ok, lat);
    repeat (5) begin
      @(negedge clk);
      check("bp_z", 32'(res_z), 32'h0000ffdc);
      check("bp_id", 32'(res_id), 0);
      check("bp_valid", 32'(res_valid), 1);
      check("bp_req_ready", 32'(req_ready), 0);
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_no_grant", 32'(req_ready), 0);
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'b10);
    tick();
    req_valid[1] = 1'b0;
    wait_res(ok, lat);
    check("bp_req1_z", 32'(res_z), 32'h00000006);
    check("bp_req1_id", 32'(res_id), 1);
    tick();

    // reset in the middle of RUN
    req_x[0 +: W] = 8'd9;
    req_y[0 +: W] = 8'd9;
    req_valid[0]  = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    if (!got) fail_now("mid_grant");
    tick();
    req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("mid_busy_after", 32'(busy), 0);
    req_x[0 +: W] = 8'd5;
    req_y[0 +: W] = 8'd5;
    req_valid     = 2'b11;
    @(negedge clk);
    check("mid_ptr_cleared", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    wait_res(ok, lat);
    check("mid_next_z", 32'(res_z), 32'd25);
    check("mid_next_id", 32'(res_id), 0);
    tick();

    // randomized sweep
    for (int r = 0; r < N; r++) pend[r] = 0;
    target = n_res + 1000;
    cyc    = 0;
    while (n_res < target && cyc < 60000) begin
      tick();
      cyc++;
      for (int r = 0; r < N; r++) begin
        if (gnt_seen[r]) begin
          pend[r]         = 0;
          req_valid[r]    = 1'b0;
          req_x[r*W +: W] = W'($urandom);
        end
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r]         = 1;
          req_valid[r]    = 1'b1;
          req_x[r*W +: W] = rand_op();
          req_y[r*W +: W] = rand_op();
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    if (n_res < target) fail_now("random_sweep");
    req_valid = '0;
    res_ready = 1'b1;
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
